// File: rtl/servo_angle_cmd_parser_if.sv
// ---------------------------------------------------------------------------
// servo_angle_cmd_parser_if
//   Byte-in / angle-out bundle between the UART receive stage, the angle
//   command parser and the servo PWM stage.
//
//   rx_data  [7:0]  received byte, meaningful only while rx_valid=1
//   rx_valid        one-cycle strobe per received byte
//   angle    [8:0]  current commanded angle in degrees (registered)
//   sig_done        one-cycle strobe: angle has just been updated
//   cmd_err         one-cycle strobe: a command was discarded
//
//   master : the side feeding bytes and watching the results (UART side / bench)
//   slave  : the parser itself
// ---------------------------------------------------------------------------
interface servo_angle_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [8:0] angle;
  logic       sig_done;
  logic       cmd_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  angle,
    input  sig_done,
    input  cmd_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output angle,
    output sig_done,
    output cmd_err
  );
endinterface

// File: rtl/servo_angle_cmd_parser.sv
// ---------------------------------------------------------------------------
// servo_angle_cmd_parser
//   Parses ASCII decimal angle commands ("90\r", "007\n", ...) arriving one
//   byte per rx_valid strobe, range-checks them and hands a registered 9-bit
//   angle to the PWM stage together with a one-cycle sig_done strobe.
//   Malformed, too-long, out-of-range or stalled commands are dropped and
//   reported with a one-cycle cmd_err strobe; the angle keeps its old value.
//
//   Ports:
//     sclk        system clock
//     rst         asynchronous, active-high reset
//     bus.slave   rx_data/rx_valid in, angle/sig_done/cmd_err out
//
//   Parameters:
//     ANGLE_MAX    largest accepted angle (degrees)
//     ANGLE_RESET  angle presented after reset
//     TIMEOUT_CYC  sclk cycles allowed between bytes of one command
// ---------------------------------------------------------------------------
module servo_angle_cmd_parser #(
  parameter int ANGLE_MAX   = 270,
  parameter int ANGLE_RESET = 135,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic                     sclk,
  input  logic                     rst,
  servo_angle_cmd_parser_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Counter must be able to hold TIMEOUT_CYC-1.
  localparam int                TCNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [TCNT_W-1:0] TCNT_ZERO  = {TCNT_W{1'b0}};
  localparam logic [TCNT_W-1:0] TCNT_ONE   = TCNT_W'(1);
  localparam logic [9:0]        ACC_LIMIT  = 10'(ANGLE_MAX);
  localparam logic [8:0]        ANGLE_INIT = 9'(ANGLE_RESET);

  // ASCII '0'..'9'
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // CR or LF
  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  // acc*10 + d without a multiplier; only called while acc <= 99, so the
  // 10-bit result never wraps.
  function automatic logic [9:0] acc_push(input logic [9:0] acc, input logic [3:0] d);
    return (acc << 3) + (acc << 1) + {6'b000000, d};
  endfunction

  state_e            state_q,    state_d;
  logic [9:0]        acc_q,      acc_d;
  logic [1:0]        dcnt_q,     dcnt_d;
  logic [TCNT_W-1:0] tcnt_q,     tcnt_d;
  logic [8:0]        angle_q,    angle_d;
  logic              sig_done_q, sig_done_d;
  logic              cmd_err_q,  cmd_err_d;

  logic              byte_digit_s;
  logic              byte_term_s;
  logic [3:0]        byte_val_s;

  // Classify the incoming byte; the low nibble of an ASCII digit is its value.
  always_comb begin
    byte_digit_s = is_digit(bus.rx_data);
    byte_term_s  = is_term(bus.rx_data);
    byte_val_s   = bus.rx_data[3:0];
  end

  // Next-state and output logic of the parser FSM.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    dcnt_d     = dcnt_q;
    tcnt_d     = tcnt_q;
    angle_d    = angle_q;
    sig_done_d = 1'b0;
    cmd_err_d  = 1'b0;

    if (bus.rx_valid) begin
      // A byte always restarts the inter-byte timer; it also wins over a
      // timeout that would expire in this very cycle.
      tcnt_d = TCNT_ZERO;
      case (state_q)
        ST_IDLE: begin
          if (byte_digit_s) begin
            acc_d   = {6'b000000, byte_val_s};
            dcnt_d  = 2'd1;
            state_d = ST_ACCUM;
          end else if (byte_term_s) begin
            // Stray CR/LF (second half of CR LF, blank line) is harmless.
            state_d = ST_IDLE;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = ST_DRAIN;
          end
        end

        ST_ACCUM: begin
          if (byte_digit_s) begin
            if (dcnt_q != 2'd3) begin
              acc_d  = acc_push(acc_q, byte_val_s);
              dcnt_d = dcnt_q + 2'd1;
            end else begin
              // Fourth digit: the command is too long.
              cmd_err_d = 1'b1;
              acc_d     = 10'd0;
              dcnt_d    = 2'd0;
              state_d   = ST_DRAIN;
            end
          end else if (byte_term_s) begin
            // Compare on all 10 bits so 512..999 are not folded into range.
            if (acc_q <= ACC_LIMIT) begin
              angle_d    = acc_q[8:0];
              sig_done_d = 1'b1;
            end else begin
              cmd_err_d  = 1'b1;
            end
            acc_d   = 10'd0;
            dcnt_d  = 2'd0;
            state_d = ST_IDLE;
          end else begin
            cmd_err_d = 1'b1;
            acc_d     = 10'd0;
            dcnt_d    = 2'd0;
            state_d   = ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          // Rest of a rejected command is swallowed silently up to its end.
          if (byte_term_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end

        default: begin
          acc_d   = 10'd0;
          dcnt_d  = 2'd0;
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tcnt_q == TCNT_LAST) begin
        // Command stalled: abandon it. Only a half-parsed number is worth
        // reporting; a command already being drained was reported earlier.
        cmd_err_d = (state_q == ST_ACCUM);
        acc_d     = 10'd0;
        dcnt_d    = 2'd0;
        tcnt_d    = TCNT_ZERO;
        state_d   = ST_IDLE;
      end else begin
        tcnt_d = tcnt_q + TCNT_ONE;
      end
    end else begin
      tcnt_d = TCNT_ZERO;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= 10'd0;
      dcnt_q     <= 2'd0;
      tcnt_q     <= TCNT_ZERO;
      angle_q    <= ANGLE_INIT;
      sig_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      dcnt_q     <= dcnt_d;
      tcnt_q     <= tcnt_d;
      angle_q    <= angle_d;
      sig_done_q <= sig_done_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign bus.angle    = angle_q;
  assign bus.sig_done = sig_done_q;
  assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_servo_angle_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_servo_angle_cmd_parser
//   Directed command sequences followed by randomized commands. A reference
//   model collects each command as a list of decimal digits and predicts the
//   strobes (kind, angle, cycle) into a queue; an independent monitor pops
//   that queue whenever the DUT strobes and checks angle every cycle.
// ---------------------------------------------------------------------------
module tb_servo_angle_cmd_parser;

  localparam int T        = 200;   // shortened timeout for simulation
  localparam int AMAX     = 270;
  localparam int ARESET   = 135;

  logic sclk = 1'b0;
  logic rst;
  int   cyc = 0;

  servo_angle_cmd_parser_if bus();

  servo_angle_cmd_parser #(
    .ANGLE_MAX   (AMAX),
    .ANGLE_RESET (ARESET),
    .TIMEOUT_CYC (T)
  ) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    logic [8:0] ang;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state: digits of the command so far, discard mode.
  int   mdig[$];
  bit   mdisc = 1'b0;
  int   last_c = 0;

  task automatic report(input bit ok, input string msg);
    checks++;
    if (ok) passes++;
    else    $display("FAIL %s", msg);
  endtask

  function automatic void push_exp(input bit done, input int ang, input int due);
    exp_t e;
    e.is_done = done;
    e.ang     = 9'(ang);
    e.due     = due;
    exp_q.push_back(e);
  endfunction

  // A command in progress is abandoned if no byte arrives within T cycles.
  function automatic void model_timeout(input int c);
    if ((mdisc || mdig.size() > 0) && (c - last_c > T)) begin
      if (!mdisc) push_exp(1'b0, 0, last_c + T + 1);
      mdig.delete();
      mdisc = 1'b0;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int c);
    int val;
    model_timeout(c);
    last_c = c;
    if (b >= 8'h30 && b <= 8'h39) begin
      if (!mdisc) begin
        if (mdig.size() == 3) begin
          push_exp(1'b0, 0, c + 1);
          mdig.delete();
          mdisc = 1'b1;
        end else begin
          mdig.push_back(int'(b) - 48);
        end
      end
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (mdisc) begin
        mdisc = 1'b0;
      end else if (mdig.size() > 0) begin
        val = 0;
        foreach (mdig[i]) val = val * 10 + mdig[i];
        if (val <= AMAX) push_exp(1'b1, val, c + 1);
        else             push_exp(1'b0, 0, c + 1);
        mdig.delete();
      end
    end else begin
      if (!mdisc) begin
        push_exp(1'b0, 0, c + 1);
        mdig.delete();
        mdisc = 1'b1;
      end
    end
  endfunction

  // Present byte b 'gap' cycles after the previous one (gap=1: back-to-back).
  task automatic send_byte(input logic [7:0] b, input int gap);
    model_timeout(cyc + gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge sclk);
      bus.rx_valid = 1'b0;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    model_byte(b, cyc);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic idle(input int n);
    model_timeout(cyc + n);
    for (int i = 0; i < n; i++) begin
      @(negedge sclk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle(3);
    rst = 1'b1;
    @(negedge sclk);
    rst = 1'b0;
    report(exp_q.size() == 0,
           $sformatf("reset_pending: %0d strobes still expected, required 0", exp_q.size()));
    exp_q.delete();
    mdig.delete();
    mdisc = 1'b0;
  endtask

  function automatic int rand_gap();
    if ($urandom_range(0, 29) == 0) return int'($urandom_range(T - 2, T + 3));
    return int'($urandom_range(1, 4));
  endfunction

  task automatic send_random_cmd();
    int         n;
    logic [7:0] b;
    n = int'($urandom_range(1, 4));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 15) == 0)
        b = 8'($urandom_range(0, 255));
      else if (i == 0 && $urandom_range(0, 1) == 1)
        b = 8'h30 + 8'($urandom_range(0, 2));
      else
        b = 8'h30 + 8'($urandom_range(0, 9));
      send_byte(b, rand_gap());
    end
    b = ($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A;
    send_byte(b, rand_gap());
    if ($urandom_range(0, 3) == 0) send_byte(8'h0A, rand_gap());
  endtask

  // Monitor: strobes against the expectation queue, angle every cycle.
  initial begin : monitor
    exp_t       e;
    logic [8:0] mon_angle;
    mon_angle = 9'(ARESET);
    forever begin
      @(negedge sclk);
      if (rst) begin
        mon_angle = 9'(ARESET);
      end else begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          e = exp_q.pop_front();
          report(1'b0, $sformatf("missing_strobe: no strobe by cycle %0d, required done=%0b at cycle %0d",
                                 cyc, e.is_done, e.due));
        end
        if (bus.sig_done === 1'b1 || bus.cmd_err === 1'b1) begin
          if (exp_q.size() == 0) begin
            report(1'b0, $sformatf("unexpected_strobe: sig_done=%0b cmd_err=%0b at cycle %0d, required none",
                                   bus.sig_done, bus.cmd_err, cyc));
          end else begin
            e = exp_q.pop_front();
            report((bus.sig_done === e.is_done) && (bus.cmd_err === ~e.is_done) && (cyc == e.due),
                   $sformatf("strobe: sig_done=%0b cmd_err=%0b cycle=%0d, required sig_done=%0b cmd_err=%0b cycle=%0d",
                             bus.sig_done, bus.cmd_err, cyc, e.is_done, ~e.is_done, e.due));
            if (e.is_done) mon_angle = e.ang;
          end
        end
        report(bus.angle === mon_angle,
               $sformatf("angle: got %0d at cycle %0d, required %0d", bus.angle, cyc, mon_angle));
      end
    end
  end

  initial begin : stimulus
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge sclk);
    report((bus.angle === 9'(ARESET)) && (bus.sig_done === 1'b0) && (bus.cmd_err === 1'b0),
           $sformatf("reset_state: angle=%0d sig_done=%0b cmd_err=%0b, required %0d 0 0",
                     bus.angle, bus.sig_done, bus.cmd_err, ARESET));
    rst = 1'b0;

    // Slow command.
    send_str("90\r", 100);
    idle(5);
    // Upper boundary, CR LF, then zero back-to-back.
    send_str("270\r\n", 1);
    send_str("0\n", 1);
    idle(5);
    // Out of range and too long.
    send_str("271\r", 1);
    send_str("1234\r", 1);
    send_str("999\r", 2);
    idle(5);
    // Junk in the middle, then a good command; leading zeros.
    send_str("4x5\r", 1);
    send_str("45\r", 1);
    send_str("007\r", 1);
    send_str("45\r", 3);      // same value again still strobes
    idle(5);
    // Stall in ACCUM, then a fresh command.
    send_str("12", 1);
    idle(T);
    send_str("3\r", 1);
    idle(5);
    // Gap of exactly T cycles: the byte wins over the timeout.
    send_str("1", 1);
    idle(T - 1);
    send_str("2\r", 1);
    idle(5);
    // Stall while draining: no error reported for the timeout.
    send_str("x9", 1);
    idle(T + 5);
    send_str("8\r", 1);
    idle(5);
    // Reset in the middle of a command.
    send_str("18", 1);
    do_reset();
    idle(4);
    send_str("0\r", 1);
    idle(5);

    for (int k = 0; k < 250; k++) send_random_cmd();

    idle(T + 10);
    report(exp_q.size() == 0,
           $sformatf("drain_end: %0d strobes never seen, required 0", exp_q.size()));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop in case something stalls the stimulus.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required stimulus to complete");
    $fatal(1, "watchdog");
  end

endmodule
